// File: rtl/or1k_bp_pkg.sv
// or1k_bp_pkg: shared counter type, weak-state constants and the saturating update rule
// for the OR1K branch predictor.
// Counter width is fixed here because bp_cnt_t is a package type.
// The top module checks that its CNT_WIDTH parameter matches BP_CNT_WIDTH.
package or1k_bp_pkg;

    localparam int BP_CNT_WIDTH = 2;

    typedef logic [BP_CNT_WIDTH-1:0] bp_cnt_t;

    localparam bp_cnt_t WEAK_T  = bp_cnt_t'(1 << (BP_CNT_WIDTH - 1));
    localparam bp_cnt_t WEAK_NT = bp_cnt_t'((1 << (BP_CNT_WIDTH - 1)) - 1);
    localparam bp_cnt_t CNT_MAX = '1;

    // A first-time entry lands on the weak state matching the outcome.
    // Trained entries saturate at both ends.
    function automatic bp_cnt_t bp_sat_update(bp_cnt_t cnt, logic valid, logic taken);
        return !valid ? (taken ? WEAK_T : WEAK_NT) :
               taken  ? ((cnt == CNT_MAX) ? cnt : cnt + 1'b1) :
                        ((cnt == '0) ? cnt : cnt - 1'b1);
    endfunction

endpackage

// File: rtl/or1k_bp_counter_table.sv
// or1k_bp_counter_table: saturating-counter and valid-bit storage with one combinational
// read port and one synchronous write (training) port.
// Ports:
//   clk, rst_n   clock, async active-low clear (counters -> WEAK_NT, valid -> 0)
//   i_rd_idx     read index; o_rd_cnt / o_rd_valid are the same-cycle contents
//   i_wr_en      apply one training update at i_wr_idx with outcome i_wr_taken
module or1k_bp_counter_table
    import or1k_bp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output bp_cnt_t          o_rd_cnt,
    output logic             o_rd_valid,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    bp_cnt_t          r_cnt [DEPTH];
    logic [DEPTH-1:0] r_valid;

    // Read returns the stored value, so a same-cycle write is not bypassed.
    assign o_rd_cnt   = r_cnt[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_cnt[i] <= WEAK_NT;
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_cnt[i_wr_idx]   <= bp_sat_update(r_cnt[i_wr_idx], r_valid[i_wr_idx], i_wr_taken);
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/or1k_branch_predictor_saturation_table.sv
// or1k_branch_predictor_saturation_table: dynamic l.bf/l.bnf predictor using a PC-indexed
// table of saturating counters.
// Never-trained entries fall back to the static rule: backward branches are predicted
// taken, forward branches not taken.
// Optional feature: define OR1K_BP_GSHARE_EN to XOR a non-speculative global history into
// the index.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   padv_decode_i         decode advances: latch the decode index
//   padv_execute_i        execute advances: move the index to execute and allow training
//   decode_pc_i           PC of the decode instruction
//   op_bf_i, op_bnf_i     decode holds l.bf / l.bnf
//   immjbr_upper_i        upper branch offset bits; bit 9 is the sign
//   predicted_flag_o      predicted SR[F] for the decode branch
//   execute_op_brcond_i   execute holds a conditional branch
//   execute_op_bf_i       that branch is l.bf (else l.bnf)
//   flag_i                resolved SR[F] for the execute branch
module or1k_branch_predictor_saturation_table
    import or1k_bp_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int TABLE_DEPTH          = 64,
    parameter int CNT_WIDTH            = 2,
    parameter int HISTORY_WIDTH        = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            padv_decode_i,
    input  logic                            padv_execute_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
    input  logic                            op_bf_i,
    input  logic                            op_bnf_i,
    input  logic [9:0]                      immjbr_upper_i,
    output logic                            predicted_flag_o,
    input  logic                            execute_op_brcond_i,
    input  logic                            execute_op_bf_i,
    input  logic                            flag_i
);

    localparam int IDX_W = $clog2(TABLE_DEPTH);

    if (CNT_WIDTH != BP_CNT_WIDTH) begin : g_cnt_width_check
        $error("CNT_WIDTH must equal or1k_bp_pkg::BP_CNT_WIDTH");
    end
    if (HISTORY_WIDTH > IDX_W || HISTORY_WIDTH < 2) begin : g_hist_width_check
        $error("HISTORY_WIDTH must be in 2..IDX_W");
    end

    logic [IDX_W-1:0] w_pc_idx;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] r_dec_idx;
    logic [IDX_W-1:0] r_exe_idx;
    bp_cnt_t          w_rd_cnt;
    logic             w_rd_valid;
    logic             w_taken_pred;
    logic             w_upd;
    logic             w_taken_act;
    logic             w_unused_in;

    // Word-address bits select the entry; the rest of the PC only aliases.
    assign w_pc_idx    = decode_pc_i[IDX_W+1:2];
    assign w_unused_in = ^{decode_pc_i[OPTION_OPERAND_WIDTH-1:IDX_W+2], decode_pc_i[1:0],
                           immjbr_upper_i[8:0]};

`ifdef OR1K_BP_GSHARE_EN
    logic [HISTORY_WIDTH-1:0] r_ghr;

    // History advances only on resolved branches, so it never needs repair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ghr <= '0;
        else if (w_upd) r_ghr <= {r_ghr[HISTORY_WIDTH-2:0], w_taken_act};
    end

    assign w_idx = w_pc_idx ^ IDX_W'(r_ghr);
`else
    assign w_idx = w_pc_idx;
`endif

    // The execute index is the one computed at decode time.
    // Training never recomputes it from a PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_idx <= '0;
            r_exe_idx <= '0;
        end else begin
            if (padv_decode_i) r_dec_idx <= w_idx;
            if (padv_execute_i) r_exe_idx <= r_dec_idx;
        end
    end

    assign w_upd       = execute_op_brcond_i & padv_execute_i;
    assign w_taken_act = execute_op_bf_i ? flag_i : !flag_i;

    or1k_bp_counter_table #(
        .DEPTH (TABLE_DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (w_idx),
        .o_rd_cnt   (w_rd_cnt),
        .o_rd_valid (w_rd_valid),
        .i_wr_en    (w_upd),
        .i_wr_idx   (r_exe_idx),
        .i_wr_taken (w_taken_act)
    );

    assign w_taken_pred     = w_rd_valid ? w_rd_cnt[CNT_WIDTH-1] : immjbr_upper_i[9];
    assign predicted_flag_o = (op_bf_i & w_taken_pred) | (op_bnf_i & !w_taken_pred);

endmodule
